// File: rtl/usrt_rx_frame.sv
// usrt_rx_frame: parametrised USRT frame receiver with parity/framing checks and a one-entry valid/ready holding register
//   pClk       in   system clock, rising edge
//   rst        in   synchronous active-high reset
//   uTick      in   baud enable; rx is sampled only when high
//   rx         in   serial line, idle high, LSB first
//   rx_data    out  received word, valid while rx_valid
//   rx_valid   out  holding register full
//   rx_ready   in   consumer accepts on rx_valid&rx_ready
//   parity_err out  one-cycle pulse, frame dropped on parity mismatch
//   frame_err  out  one-cycle pulse, frame dropped on a zero stop bit
//   overrun    out  one-cycle pulse, good frame dropped, holding register full
//   busy       out  high whenever not idle
module usrt_rx_frame #(
    parameter int DATA_W     = 8,
    parameter int PARITY_EN  = 1,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic              pClk,
    input  logic              rst,
    input  logic              uTick,
    input  logic              rx,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              parity_err,
    output logic              frame_err,
    output logic              overrun,
    output logic              busy
);
    typedef enum logic [2:0] {IDLE, DATA, PARITY, STOP, BREAK} state_t;
    state_t state, stateNext;
    logic [3:0] bitCnt;
    logic stopCnt;
    logic [DATA_W-1:0] shReg;
    logic perr, ferr;
    logic lastStop, frameBad, good, doLoad, doParErr, doFrameErr, doOverrun;

    always_ff @(posedge pClk)
        state <= rst ? IDLE : stateNext;

    always_comb begin
        stateNext = state;
        if (uTick)
            case (state)
                IDLE:    stateNext = rx ? IDLE : DATA;
                DATA:    stateNext = (bitCnt == 4'(DATA_W-1)) ? ((PARITY_EN != 0) ? PARITY : STOP) : DATA;
                PARITY:  stateNext = STOP;
                STOP:    stateNext = lastStop ? (frameBad ? BREAK : IDLE) : STOP;
                BREAK:   stateNext = rx ? IDLE : BREAK;
                default: stateNext = IDLE;
            endcase
    end

    // frameBad folds in the current (last) stop sample, which is not yet latched into ferr
    always_comb begin
        lastStop   = (state == STOP) && uTick && (stopCnt == 1'(STOP_BITS-1));
        frameBad   = ferr | ~rx;
        good       = lastStop & ~frameBad & ~perr;
        doFrameErr = lastStop & frameBad;
        doParErr   = lastStop & ~frameBad & perr;
        doLoad     = good & (~rx_valid | rx_ready);
        doOverrun  = good & rx_valid & ~rx_ready;
        busy       = state != IDLE;
    end

    always_ff @(posedge pClk) begin
        if (rst) begin
            bitCnt     <= '0;
            stopCnt    <= 1'b0;
            shReg      <= '0;
            perr       <= 1'b0;
            ferr       <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            parity_err <= doParErr;
            frame_err  <= doFrameErr;
            overrun    <= doOverrun;
            rx_valid   <= doLoad | (rx_valid & ~rx_ready);
            if (doLoad)
                rx_data <= shReg;
            if (uTick)
                case (state)
                    IDLE: begin
                        bitCnt <= '0;
                        perr   <= 1'b0;
                        ferr   <= 1'b0;
                    end
                    DATA: begin
                        shReg   <= {rx, shReg[DATA_W-1:1]};
                        bitCnt  <= bitCnt + 4'd1;
                        stopCnt <= 1'b0;
                    end
                    PARITY: perr <= (^shReg ^ rx) != 1'(PARITY_ODD);
                    STOP: begin
                        ferr    <= ferr | ~rx;
                        stopCnt <= stopCnt + 1'b1;
                    end
                    default: ;
                endcase
        end
    end
endmodule
